rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
Parametrised BCD time-of-day generator that supersedes the fixed 25 MHz seconds counter feeding the VGA clock display. It adds a configurable input frequency, correct hour wrap, and a selectable 12/24-hour mode. It also adds run/pause, a validated time load, and an hh:mm alarm. Digit outputs drive the display renderer directly; the tick pulses are for other logic.

Parameters:
CLK_FREQ_HZ, 25000000, clk cycles per second; prescaler terminal count = CLK_FREQ_HZ-1; legal range >= 2.
MODE_24H, 1, 1 = 24-hour (00..23); 0 = 12-hour (01..12 with pm flag).

Ports:
clk  in  1  system clock; all logic on posedge clk.
reset  in  1  synchronous, active-high reset.
run  in  1  1 = prescaler advances; 0 = prescaler and time frozen (values held, not cleared).
load  in  1  single-cycle strobe; load load_time/load_pm.
load_time  in  24  BCD {ht,hu,mt,mu,st,su}, 4 bits each, ht in [23:20].
load_pm  in  1  pm value for load; ignored when MODE_24H=1.
alarm_en  in  1  enables alarm compare.
alarm_hm  in  16  BCD {ht,hu,mt,mu} alarm time; in 12h mode interpreted with alarm_pm.
alarm_pm  in  1  alarm pm qualifier, 12h mode only.
hours_tens, hours_units, minutes_tens, minutes_units, seconds_tens, seconds_units  out  4 each  BCD time digits, registered.
pm  out  1  pm flag; constant 0 when MODE_24H=1.
sec_tick  out  1  one-cycle pulse coincident with each seconds increment.
day_tick  out  1  one-cycle pulse coincident with the midnight rollover.
alarm_hit  out  1  one-cycle pulse; see alarm rule.
load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (synchronous, highest priority): prescaler=0; all pulses=0; pm=0. Time = 00:00:00 if MODE_24H=1, else 12:00:00 with pm=0 (12 AM).
- Prescaler: counts 0..CLK_FREQ_HZ-1 while run=1. On the cycle it equals CLK_FREQ_HZ-1 it returns to 0 and an advance occurs. Period is exactly CLK_FREQ_HZ cycles. run=0 holds the count.
- Advance: all digits update on the same edge. sec_tick=1 in the cycle the new value is first visible (registered, zero extra latency).
- Digit rules: su 9->0 carries to st; st 5->0 carries to mu; mu 9->0 carries to mt; mt 5->0 carries to hours.
- 24h hours: 09->10, 19->20, 23->00. 23:59:59->00:00:00 asserts day_tick.
- 12h hours: 09->10, 11->12 toggles pm, 12->01 with pm unchanged. 11:59:59 pm=1 -> 12:00:00 pm=0 asserts day_tick.
- Hours never show 24+ (24h) or 00/13+ (12h).
- Load priority: load beats advance in the same cycle. Prescaler clears to 0; sec_tick, day_tick and alarm_hit stay 0 that cycle.
- Load validity: every digit <=9; st,mt <=5; hours 00..23 (24h) or 01..12 (12h).
- Valid load: digits and pm take the new values on the next edge.
- Invalid load: time and pm are unchanged, load_err pulses 1 cycle, and the prescaler is still cleared.
- Alarm: alarm_hit pulses when an advance produces time == alarm_hm:00 (and pm == alarm_pm in 12h) while alarm_en=1. A load landing on that time does not fire. An invalid alarm_hm never matches.
- All pulses default 0 in every cycle not stated above.
- Reset mid-second discards the partial prescaler count.
- run toggling never generates or drops an advance except by freezing the count.

Test Plan:
1. CLK_FREQ_HZ=4, MODE_24H=1: release reset, run=1 -> sec_tick every 4th cycle; after 40 cycles display 00:00:10.
2. 24h: load 23:59:59, run 4 cycles -> 00:00:00, day_tick and sec_tick high same cycle. Load 09:59:59 -> 10:00:00 after 1 s.
3. MODE_24H=0: load 11:59:59 pm=0 -> 12:00:00 pm=1, no day_tick. Load 12:59:59 pm=1 -> 01:00:00 pm=1. Load 11:59:59 pm=1 -> 12:00:00 pm=0 with day_tick.
4. Load 24:00:00 (24h), 00:30:00 (12h), 12:60:00, and su=0xA -> each gives a load_err pulse with time unchanged. load with prescaler at 3 and run=1 -> no sec_tick; next tick 4 cycles later.
5. alarm_en=1, alarm_hm=07:30: load 07:29:59, run -> alarm_hit exactly once at 07:30:00. Direct load of 07:30:00 -> no alarm_hit. alarm_en=0 -> none.
6. run=0 for 10 cycles mid-second, then run=1 -> tick delayed by exactly 10 cycles. reset asserted mid-count -> reset time next edge, all pulses 0.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD time-of-day generator for the VGA clock display.
//
// A prescaler divides clk down to one advance per second. Each advance
// steps the BCD time by one second with full carry through to hours.
// Hours wrap in either 24-hour mode (00..23) or 12-hour mode (01..12 + pm).
// The time can be loaded; invalid load values are rejected. An hh:mm alarm
// fires once, on the advance that reaches hh:mm:00.
//
// Parameters:
//   CLK_FREQ_HZ  clk cycles per second (>= 2)
//   MODE_24H     1 = 24-hour display, 0 = 12-hour display with pm flag
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   run                     1 = prescaler counts, 0 = prescaler and time frozen
//   load, load_time,        one-cycle load strobe, BCD {ht,hu,mt,mu,st,su},
//   load_pm                 and the pm value (12h only)
//   alarm_en, alarm_hm,     alarm enable, BCD {ht,hu,mt,mu}, and the
//   alarm_pm                pm qualifier (12h only)
//   hours_tens..seconds_units  registered BCD digits
//   pm                      pm flag (always 0 in 24h mode)
//   sec_tick, day_tick      one-cycle pulses on each second / midnight rollover
//   alarm_hit, load_err     one-cycle pulses on alarm match / rejected load
module rtc_timekeeper #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int MODE_24H    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        load_pm,
  input  logic        alarm_en,
  input  logic [15:0] alarm_hm,
  input  logic        alarm_pm,
  output logic [3:0]  hours_tens,
  output logic [3:0]  hours_units,
  output logic [3:0]  minutes_tens,
  output logic [3:0]  minutes_units,
  output logic [3:0]  seconds_tens,
  output logic [3:0]  seconds_units,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_tick,
  output logic        alarm_hit,
  output logic        load_err
);

  localparam int            PW     = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] TC     = PW'(CLK_FREQ_HZ - 1);
  // 12-hour mode powers up at 12 AM, 24-hour mode at 00.
  localparam logic [3:0]    RST_HT = (MODE_24H != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0]    RST_HU = (MODE_24H != 0) ? 4'd0 : 4'd2;

  function automatic logic hours_ok(input logic [3:0] t, input logic [3:0] u);
    if (MODE_24H != 0)
      return (t <= 4'd2) && (u <= 4'd9) && !(t == 4'd2 && u > 4'd3);
    else
      return (t == 4'd0 && u != 4'd0 && u <= 4'd9) || (t == 4'd1 && u <= 4'd2);
  endfunction

  function automatic logic time_ok(input logic [23:0] t);
    return hours_ok(t[23:20], t[19:16]) &&
           (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction

  logic [PW-1:0] presc;
  logic          adv;
  logic          load_ok, alarm_ok, alarm_match;
  logic          c_st, c_mu, c_mt, c_hr;
  logic [3:0]    n_ht, n_hu, n_mt, n_mu, n_st, n_su;
  logic          n_pm, n_day;

  assign adv      = run && (presc == TC);
  assign load_ok  = time_ok(load_time);
  // Seconds are forced to 00, so only hh:mm needs validating.
  assign alarm_ok = time_ok({alarm_hm, 8'h00});

  // Carry chain: each stage carries when every lower digit is at its max.
  assign c_st = (seconds_units == 4'd9);
  assign c_mu = c_st && (seconds_tens  == 4'd5);
  assign c_mt = c_mu && (minutes_units == 4'd9);
  assign c_hr = c_mt && (minutes_tens  == 4'd5);

  always_comb begin
    n_ht  = hours_tens;
    n_hu  = hours_units;
    n_mt  = minutes_tens;
    n_mu  = minutes_units;
    n_st  = seconds_tens;
    n_pm  = pm;
    n_day = 1'b0;
    n_su  = c_st ? 4'd0 : seconds_units + 4'd1;
    if (c_st) n_st = c_mu ? 4'd0 : seconds_tens + 4'd1;
    if (c_mu) n_mu = c_mt ? 4'd0 : minutes_units + 4'd1;
    if (c_mt) n_mt = c_hr ? 4'd0 : minutes_tens + 4'd1;
    if (c_hr) begin
      if (MODE_24H != 0) begin
        if (hours_tens == 4'd2 && hours_units == 4'd3) begin
          n_ht  = 4'd0;
          n_hu  = 4'd0;
          n_day = 1'b1;
        end else if (hours_units == 4'd9) begin
          n_ht = hours_tens + 4'd1;
          n_hu = 4'd0;
        end else begin
          n_hu = hours_units + 4'd1;
        end
      end else begin
        if (hours_tens == 4'd1 && hours_units == 4'd2) begin
          n_ht = 4'd0;
          n_hu = 4'd1;
        end else if (hours_tens == 4'd1 && hours_units == 4'd1) begin
          // 11 -> 12 flips am/pm; leaving pm is the start of a new day.
          n_hu  = 4'd2;
          n_pm  = ~pm;
          n_day = pm;
        end else if (hours_units == 4'd9) begin
          n_ht = 4'd1;
          n_hu = 4'd0;
        end else begin
          n_hu = hours_units + 4'd1;
        end
      end
    end
  end

  // Compared against the post-advance time so the pulse lines up with the display.
  assign alarm_match = alarm_en && alarm_ok &&
                       ({n_ht, n_hu, n_mt, n_mu} == alarm_hm) &&
                       (n_st == 4'd0) && (n_su == 4'd0) &&
                       ((MODE_24H != 0) || (n_pm == alarm_pm));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc         <= '0;
      hours_tens    <= RST_HT;
      hours_units   <= RST_HU;
      minutes_tens  <= 4'd0;
      minutes_units <= 4'd0;
      seconds_tens  <= 4'd0;
      seconds_units <= 4'd0;
      pm            <= 1'b0;
      sec_tick      <= 1'b0;
      day_tick      <= 1'b0;
      alarm_hit     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        // Any load, accepted or not, restarts the second.
        presc <= '0;
        if (load_ok) begin
          {hours_tens, hours_units, minutes_tens, minutes_units,
           seconds_tens, seconds_units} <= load_time;
          pm <= (MODE_24H != 0) ? 1'b0 : load_pm;
        end else begin
          load_err <= 1'b1;
        end
      end else if (adv) begin
        presc <= '0;
        {hours_tens, hours_units, minutes_tens, minutes_units,
         seconds_tens, seconds_units} <= {n_ht, n_hu, n_mt, n_mu, n_st, n_su};
        pm        <= n_pm;
        sec_tick  <= 1'b1;
        day_tick  <= n_day;
        alarm_hit <= alarm_match;
      end else if (run) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Testbench for rtc_timekeeper: one 24-hour and one 12-hour instance, both
// with CLK_FREQ_HZ=4. Stimulus queues each expected pulse event, with the
// cycle it must appear on. A negedge monitor pops and compares every cycle
// in which a DUT raises any pulse.
module tb_rtc_timekeeper;

  typedef struct {
    logic [23:0] t;
    logic        pm;
    logic [3:0]  f;      // {sec, day, alarm, err}
    int          stamp;
  } exp_t;

  localparam logic [3:0] SEC = 4'b1000;
  localparam logic [3:0] DAY = 4'b0100;
  localparam logic [3:0] ALM = 4'b0010;
  localparam logic [3:0] ERR = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Instance A: 24h
  logic        ra = 1'b1, runa = 1'b0, lda = 1'b0, lpa = 1'b0, aena = 1'b0, apma = 1'b0;
  logic [23:0] lta = '0;
  logic [15:0] ahma = '0;
  logic [23:0] tm_a;
  logic        pm_a;
  logic [3:0]  fl_a;
  // Instance B: 12h
  logic        rb = 1'b1, runb = 1'b0, ldb = 1'b0, lpb = 1'b0, aenb = 1'b0, apmb = 1'b0;
  logic [23:0] ltb = '0;
  logic [15:0] ahmb = '0;
  logic [23:0] tm_b;
  logic        pm_b;
  logic [3:0]  fl_b;

  rtc_timekeeper #(.CLK_FREQ_HZ(4), .MODE_24H(1)) dut_a (
    .clk(clk), .reset(ra), .run(runa), .load(lda), .load_time(lta), .load_pm(lpa),
    .alarm_en(aena), .alarm_hm(ahma), .alarm_pm(apma),
    .hours_tens(tm_a[23:20]), .hours_units(tm_a[19:16]),
    .minutes_tens(tm_a[15:12]), .minutes_units(tm_a[11:8]),
    .seconds_tens(tm_a[7:4]), .seconds_units(tm_a[3:0]),
    .pm(pm_a), .sec_tick(fl_a[3]), .day_tick(fl_a[2]),
    .alarm_hit(fl_a[1]), .load_err(fl_a[0]));

  rtc_timekeeper #(.CLK_FREQ_HZ(4), .MODE_24H(0)) dut_b (
    .clk(clk), .reset(rb), .run(runb), .load(ldb), .load_time(ltb), .load_pm(lpb),
    .alarm_en(aenb), .alarm_hm(ahmb), .alarm_pm(apmb),
    .hours_tens(tm_b[23:20]), .hours_units(tm_b[19:16]),
    .minutes_tens(tm_b[15:12]), .minutes_units(tm_b[11:8]),
    .seconds_tens(tm_b[7:4]), .seconds_units(tm_b[3:0]),
    .pm(pm_b), .sec_tick(fl_b[3]), .day_tick(fl_b[2]),
    .alarm_hit(fl_b[1]), .load_err(fl_b[0]));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected event visible dly edges after the current drive point.
  task automatic expect_ev(input bit b, input logic [23:0] t, input logic p,
                           input logic [3:0] f, input int dly);
    exp_t e;
    e.t = t; e.pm = p; e.f = f; e.stamp = cyc + dly;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic load_a(input logic [23:0] t, input logic p);
    lda = 1'b1; lta = t; lpa = p;
    step(1);
    lda = 1'b0;
  endtask

  task automatic load_b(input logic [23:0] t, input logic p);
    ldb = 1'b1; ltb = t; lpb = p;
    step(1);
    ldb = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [28:0] got, input logic [28:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got t/pm/flags=%h required %h (cyc %0d)", nm, got, req, cyc);
    end
  endtask

  task automatic mon(input bit b, input logic [23:0] t, input logic p, input logic [3:0] f);
    exp_t e;
    string nm;
    nm = b ? "ev12h" : "ev24h";
    if (f != 4'b0000) begin
      tests++;
      if ((b && qb.size() == 0) || (!b && qa.size() == 0)) begin
        fails++;
        $display("FAIL %s unexpected pulse: got t=%h pm=%0b flags=%b cyc=%0d, required none",
                 nm, t, p, f, cyc);
      end else begin
        if (b) e = qb.pop_front();
        else   e = qa.pop_front();
        if (t !== e.t || p !== e.pm || f !== e.f || cyc != e.stamp) begin
          fails++;
          $display("FAIL %s: got t=%h pm=%0b flags=%b cyc=%0d, required t=%h pm=%0b flags=%b cyc=%0d",
                   nm, t, p, f, cyc, e.t, e.pm, e.f, e.stamp);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, tm_a, pm_a, fl_a);
    mon(1'b1, tm_b, pm_b, fl_b);
  end

  initial begin
    step(3);
    chk("reset24", {tm_a, pm_a, fl_a}, {24'h000000, 1'b0, 4'h0});
    chk("reset12", {tm_b, pm_b, fl_b}, {24'h120000, 1'b0, 4'h0});

    // ---- 24h: free run, one tick every 4 cycles
    ra = 1'b0; runa = 1'b1;
    for (int i = 1; i <= 10; i++)
      expect_ev(1'b0, {16'h0000, 4'(i / 10), 4'(i % 10)}, 1'b0, SEC, 4 * i);
    step(40);
    chk("count10", {tm_a, pm_a, fl_a}, {24'h000010, 1'b0, SEC});

    // ---- 24h rollovers
    expect_ev(1'b0, 24'h000000, 1'b0, SEC | DAY, 5);
    load_a(24'h235959, 1'b0);
    step(4);
    expect_ev(1'b0, 24'h100000, 1'b0, SEC, 5);
    load_a(24'h095959, 1'b0);
    step(4);

    // ---- invalid loads: time held, prescaler still restarted
    expect_ev(1'b0, 24'h100000, 1'b0, ERR, 1);
    load_a(24'h240000, 1'b0);
    expect_ev(1'b0, 24'h100000, 1'b0, ERR, 1);
    load_a(24'h126000, 1'b0);
    expect_ev(1'b0, 24'h100000, 1'b0, ERR, 1);
    load_a(24'h10000A, 1'b0);
    expect_ev(1'b0, 24'h100000, 1'b0, ERR, 1);
    load_a(24'h100060, 1'b0);
    expect_ev(1'b0, 24'h100001, 1'b0, SEC, 4);
    step(4);

    // ---- load on the terminal-count cycle beats the advance
    step(3);
    expect_ev(1'b0, 24'h050001, 1'b0, SEC, 5);
    load_a(24'h050000, 1'b0);
    chk("load_at_tc", {tm_a, pm_a, fl_a}, {24'h050000, 1'b0, 4'h0});
    step(4);

    // ---- alarm 07:30
    aena = 1'b1; ahma = 16'h0730;
    expect_ev(1'b0, 24'h073000, 1'b0, SEC | ALM, 5);
    expect_ev(1'b0, 24'h073001, 1'b0, SEC, 9);
    load_a(24'h072959, 1'b0);
    step(8);
    expect_ev(1'b0, 24'h073001, 1'b0, SEC, 5);
    load_a(24'h073000, 1'b0);
    chk("load_on_alarm", {tm_a, pm_a, fl_a}, {24'h073000, 1'b0, 4'h0});
    step(4);
    aena = 1'b0;
    expect_ev(1'b0, 24'h073000, 1'b0, SEC, 5);
    load_a(24'h072959, 1'b0);
    step(4);

    // ---- pause 10 cycles mid-second
    step(2);
    runa = 1'b0;
    expect_ev(1'b0, 24'h073001, 1'b0, SEC, 12);
    step(10);
    runa = 1'b1;
    step(2);

    // ---- reset on the cycle an advance was due
    step(3);
    ra = 1'b1;
    step(1);
    chk("reset_mid", {tm_a, pm_a, fl_a}, {24'h000000, 1'b0, 4'h0});
    ra = 1'b0;
    expect_ev(1'b0, 24'h000001, 1'b0, SEC, 4);
    step(4);
    runa = 1'b0;

    // ---- 12h mode
    rb = 1'b0; runb = 1'b1;
    expect_ev(1'b1, 24'h120000, 1'b1, SEC, 5);
    load_b(24'h115959, 1'b0);
    step(4);
    expect_ev(1'b1, 24'h010000, 1'b1, SEC, 5);
    load_b(24'h125959, 1'b1);
    step(4);
    expect_ev(1'b1, 24'h120000, 1'b0, SEC | DAY, 5);
    load_b(24'h115959, 1'b1);
    step(4);
    expect_ev(1'b1, 24'h120000, 1'b0, ERR, 1);
    load_b(24'h003000, 1'b0);
    expect_ev(1'b1, 24'h120000, 1'b0, ERR, 1);
    load_b(24'h130000, 1'b1);
    expect_ev(1'b1, 24'h120001, 1'b0, SEC, 4);
    step(4);
    expect_ev(1'b1, 24'h100000, 1'b1, SEC, 5);
    load_b(24'h095959, 1'b1);
    step(4);
    // alarm 07:30 PM: the AM crossing must not fire
    aenb = 1'b1; ahmb = 16'h0730; apmb = 1'b1;
    expect_ev(1'b1, 24'h073000, 1'b0, SEC, 5);
    load_b(24'h072959, 1'b0);
    step(4);
    expect_ev(1'b1, 24'h073000, 1'b1, SEC | ALM, 5);
    load_b(24'h072959, 1'b1);
    step(4);
    runb = 1'b0;
    step(5);

    tests++;
    if (qa.size() != 0) begin
      fails++;
      $display("FAIL missing24: %0d expected events never seen, required 0", qa.size());
    end
    tests++;
    if (qb.size() != 0) begin
      fails++;
      $display("FAIL missing12: %0d expected events never seen, required 0", qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
